// File: rtl/product_acc_pkg.sv
// Shared types and constants for the product accumulator slice.
package product_acc_pkg;

  // Width of the per-group term counter; it covers group sizes up to 255 terms.
  localparam int CNT_W = 8;

  // Width of the incoming multiplier product.
  localparam int PRODUCT_W = 16;

  // Accumulator FSM: IDLE has no partial group in flight, ACC holds 1..N_TERMS-1 terms.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/acc_adder.sv
// Combinational accumulator adder: ACC_W-bit running sum plus a zero-extended
// 16-bit product, with carry-out reporting.
// Build option: PRODUCT_ACC_SATURATE_EN clamps the result to all-ones on carry;
// without it the result wraps modulo 2^ACC_W.
module acc_adder
  import product_acc_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0]     acc_i,
  input  logic [PRODUCT_W-1:0] product_i,
  output logic [ACC_W-1:0]     acc_o,
  output logic                 carry_o
);

  logic [ACC_W:0] raw_sum_s;

  // One-bit-wider add so the carry out of bit ACC_W-1 is visible.
  always_comb begin
    raw_sum_s = {1'b0, acc_i} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, product_i};
    carry_o   = raw_sum_s[ACC_W];
  end

`ifdef PRODUCT_ACC_SATURATE_EN
  // Clamp to the largest representable value whenever the add carries out.
  // Once clamped, any further non-zero product carries again, so the value
  // stays pinned for the rest of the group.
  always_comb begin
    if (raw_sum_s[ACC_W]) begin
      acc_o = {ACC_W{1'b1}};
    end else begin
      acc_o = raw_sum_s[ACC_W-1:0];
    end
  end
`else
  // Plain modulo-2^ACC_W wrap: drop the carry bit.
  always_comb begin
    acc_o = raw_sum_s[ACC_W-1:0];
  end
`endif

endmodule

// File: rtl/product_accumulator.sv
// Groups N_TERMS consecutive valid multiplier products into one registered sum
// with a single-cycle valid strobe. Groups run back-to-back with no dead cycle.
// Build option: PRODUCT_ACC_SATURATE_EN (saturating accumulation, see acc_adder).
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [PRODUCT_W-1:0] product,
  input  logic                 clear,
  output logic [ACC_W-1:0]     sum,
  output logic                 ena_out,
  output logic                 ovf,
  output logic [CNT_W-1:0]     count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS);

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic             sticky_q;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;
  logic             ena_out_q;

  logic             fresh_d;
  logic [ACC_W-1:0] base_d;
  logic [CNT_W-1:0] count_d;
  logic [ACC_W-1:0] acc_d;
  logic             carry_d;
  logic             ovf_d;
  logic             done_d;

  // Decide whether this product opens a new group (nothing in flight, or the
  // partial group is being discarded) and pick the adder base and term index.
  always_comb begin
    case (state_q)
      IDLE:    fresh_d = 1'b1;
      ACC:     fresh_d = clear;
      default: fresh_d = 1'b1;
    endcase
    if (fresh_d) begin
      base_d  = {ACC_W{1'b0}};
      count_d = CNT_W'(1);
    end else begin
      base_d  = acc_q;
      count_d = count_q + CNT_W'(1);
    end
  end

  acc_adder #(
    .ACC_W(ACC_W)
  ) u_acc_adder (
    .acc_i    (base_d),
    .product_i(product),
    .acc_o    (acc_d),
    .carry_o  (carry_d)
  );

  // Fold this add's carry into the group's overflow history and detect the last term.
  always_comb begin
    if (fresh_d) begin
      ovf_d = carry_d;
    end else begin
      ovf_d = sticky_q | carry_d;
    end
    done_d = (count_d == LAST_CNT);
  end

  // Group FSM, accumulator, counter and registered result/strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= {ACC_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      sticky_q  <= 1'b0;
      sum_q     <= {ACC_W{1'b0}};
      ovf_q     <= 1'b0;
      ena_out_q <= 1'b0;
    end else begin
      ena_out_q <= 1'b0;
      if (ena) begin
        if (done_d) begin
          // Last term: publish the result and restart empty.
          sum_q     <= acc_d;
          ovf_q     <= ovf_d;
          ena_out_q <= 1'b1;
          acc_q     <= {ACC_W{1'b0}};
          count_q   <= {CNT_W{1'b0}};
          sticky_q  <= 1'b0;
          state_q   <= IDLE;
        end else begin
          acc_q    <= acc_d;
          count_q  <= count_d;
          sticky_q <= ovf_d;
          state_q  <= ACC;
        end
      end else if (clear) begin
        // Abort the partial group; published result is left untouched.
        acc_q    <= {ACC_W{1'b0}};
        count_q  <= {CNT_W{1'b0}};
        sticky_q <= 1'b0;
        state_q  <= IDLE;
      end else begin
        state_q <= state_q;
      end
    end
  end

  assign sum     = sum_q;
  assign ovf     = ovf_q;
  assign ena_out = ena_out_q;
  assign count   = count_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator (N_TERMS=4, ACC_W=18) plus a
// second instance with ACC_W=17 for the overflow scenario.
module tb_product_accumulator;

  localparam int N     = 4;
  localparam int AW    = 18;
  localparam int AW2   = 17;
  localparam longint MAXV = (64'd1 << AW) - 64'd1;

  typedef struct {
    logic [AW-1:0] sum;
    logic          ovf;
    int            cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [15:0]   product;
  logic          clear;
  logic [AW-1:0] sum;
  logic          ena_out;
  logic          ovf;
  logic [7:0]    count;

  logic           ena2;
  logic [15:0]    product2;
  logic           clear2;
  logic [AW2-1:0] sum2;
  logic           ena_out2;
  logic           ovf2;
  logic [7:0]     count2;

  int n_vec;
  int n_err;
  int cyc;

  exp_t sb_q[$];
  exp_t mon_x;

  logic [AW-1:0] m_acc;
  logic [7:0]    m_cnt;
  logic          m_stk;
  logic [AW-1:0] m_sum;
  logic          m_ovf;

  product_accumulator #(.N_TERMS(N), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .ena(ena), .product(product), .clear(clear),
    .sum(sum), .ena_out(ena_out), .ovf(ovf), .count(count)
  );

  product_accumulator #(.N_TERMS(N), .ACC_W(AW2)) dut2 (
    .clk(clk), .rst(rst), .ena(ena2), .product(product2), .clear(clear2),
    .sum(sum2), .ena_out(ena_out2), .ovf(ovf2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every ena_out must match the oldest expected group result
  // and arrive in the cycle right after its last term was sampled.
  always @(negedge clk) begin
    if (ena_out === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL strobe: unexpected ena_out at cycle %0d, sum=%0d", cyc, sum);
      end else begin
        mon_x = sb_q.pop_front();
        if (sum !== mon_x.sum || ovf !== mon_x.ovf || cyc != mon_x.cyc) begin
          n_err++;
          $display("FAIL strobe: got sum=%0d ovf=%0b cycle=%0d, expected sum=%0d ovf=%0b cycle=%0d",
                   sum, ovf, cyc, mon_x.sum, mon_x.ovf, mon_x.cyc);
        end
      end
    end
  end

  // Apply one cycle of stimulus to the main DUT, advance the model, then check
  // the held outputs and the term counter after the edge.
  task automatic drive(input logic e, input logic [15:0] p, input logic c, input logic r);
    longint s;
    logic   fresh;
    logic   carry;
    logic   stk;
    int     nc;
    exp_t   x;
    ena = e; product = p; clear = c; rst = r;
    if (r) begin
      m_acc = '0; m_cnt = 8'd0; m_stk = 1'b0; m_sum = '0; m_ovf = 1'b0;
    end else if (e) begin
      fresh = (m_cnt == 8'd0) || c;
      s     = (fresh ? 64'd0 : longint'(m_acc)) + longint'(p);
      carry = (s > MAXV);
      stk   = (fresh ? 1'b0 : m_stk) | carry;
`ifdef PRODUCT_ACC_SATURATE_EN
      if (carry) s = MAXV;
`else
      s = s & MAXV;
`endif
      nc = fresh ? 1 : int'(m_cnt) + 1;
      if (nc == N) begin
        x.sum = AW'(s); x.ovf = stk; x.cyc = cyc + 1;
        sb_q.push_back(x);
        m_sum = AW'(s); m_ovf = stk;
        m_acc = '0; m_cnt = 8'd0; m_stk = 1'b0;
      end else begin
        m_acc = AW'(s); m_cnt = 8'(nc); m_stk = stk;
      end
    end else if (c) begin
      m_acc = '0; m_cnt = 8'd0; m_stk = 1'b0;
    end
    @(posedge clk);
    #1;
    ena = 1'b0; clear = 1'b0; rst = 1'b0; product = 16'd0;
    n_vec++;
    if (count !== m_cnt) begin
      n_err++;
      $display("FAIL count: got %0d expected %0d at cycle %0d", count, m_cnt, cyc);
    end
    n_vec++;
    if (sum !== m_sum || ovf !== m_ovf) begin
      n_err++;
      $display("FAIL held_result: got sum=%0d ovf=%0b expected sum=%0d ovf=%0b at cycle %0d",
               sum, ovf, m_sum, m_ovf, cyc);
    end
  endtask

  // One cycle of stimulus for the ACC_W=17 instance.
  task automatic step2(input logic e, input logic [15:0] p);
    ena2 = e; product2 = p;
    @(posedge clk);
    #1;
    ena2 = 1'b0; product2 = 16'd0;
  endtask

  task automatic test_reset();
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    n_vec++;
    if (ena_out !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ena_out: got %0b expected 0", ena_out);
    end
    n_vec++;
    if (sum2 !== 17'd0 || ovf2 !== 1'b0 || count2 !== 8'd0 || ena_out2 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_dut2: got sum=%0d ovf=%0b count=%0d ena_out=%0b expected all 0",
               sum2, ovf2, count2, ena_out2);
    end
  endtask

  task automatic test_consecutive();
    drive(1'b1, 16'd100, 1'b0, 1'b0);
    drive(1'b1, 16'd200, 1'b0, 1'b0);
    drive(1'b1, 16'd300, 1'b0, 1'b0);
    drive(1'b1, 16'd400, 1'b0, 1'b0);
    n_vec++;
    if (sum !== 18'd1000 || ena_out !== 1'b1) begin
      n_err++;
      $display("FAIL consecutive_sum: got sum=%0d ena_out=%0b expected sum=1000 ena_out=1", sum, ena_out);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_gaps();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(100 * i), 1'b0, 1'b0);
      if (i < 4) begin
        drive(1'b0, 16'd0, 1'b0, 1'b0);
        drive(1'b0, 16'd0, 1'b0, 1'b0);
      end
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) drive(1'b1, 16'd10, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [AW2-1:0] exp_big;
`ifdef PRODUCT_ACC_SATURATE_EN
    exp_big = 17'd131071;
`else
    exp_big = 17'd129028;
`endif
    for (int i = 0; i < 4; i++) step2(1'b1, 16'd65025);
    n_vec++;
    if (ena_out2 !== 1'b1 || sum2 !== exp_big || ovf2 !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_group: got ena_out=%0b sum=%0d ovf=%0b expected ena_out=1 sum=%0d ovf=1",
               ena_out2, sum2, ovf2, exp_big);
    end
    step2(1'b0, 16'd0);
    n_vec++;
    if (ena_out2 !== 1'b0 || sum2 !== exp_big) begin
      n_err++;
      $display("FAIL overflow_hold: got ena_out=%0b sum=%0d expected ena_out=0 sum=%0d",
               ena_out2, sum2, exp_big);
    end
    for (int i = 0; i < 4; i++) step2(1'b1, 16'd1);
    n_vec++;
    if (ena_out2 !== 1'b1 || sum2 !== 17'd4 || ovf2 !== 1'b0) begin
      n_err++;
      $display("FAIL overflow_next_group: got ena_out=%0b sum=%0d ovf=%0b expected ena_out=1 sum=4 ovf=0",
               ena_out2, sum2, ovf2);
    end
    step2(1'b0, 16'd0);
  endtask

  task automatic test_rst_mid_group();
    drive(1'b1, 16'd50, 1'b0, 1'b0);
    drive(1'b1, 16'd60, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd5, 1'b0, 1'b0);
    n_vec++;
    if (sum !== 18'd20) begin
      n_err++;
      $display("FAIL rst_mid_group_sum: got %0d expected 20", sum);
    end
    drive(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd100, 1'b0, 1'b0);
    drive(1'b1, 16'd7, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd1, 1'b0, 1'b0);
    n_vec++;
    if (sum !== 18'd10) begin
      n_err++;
      $display("FAIL clear_with_ena_sum: got %0d expected 10", sum);
    end
    drive(1'b1, 16'd300, 1'b0, 1'b0);
    drive(1'b1, 16'd300, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'd2, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; ena = 1'b0; product = 16'd0; clear = 1'b0;
    ena2 = 1'b0; product2 = 16'd0; clear2 = 1'b0;
    m_acc = '0; m_cnt = 8'd0; m_stk = 1'b0; m_sum = '0; m_ovf = 1'b0;
    test_reset();
    test_consecutive();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_rst_mid_group();
    test_clear();
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_strobes: %0d expected group results never appeared, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Downstream stage of the 8×8 multiplier. Consumes the multiplier's 16-bit `product` and its one-cycle `ena_out` strobe, and sums a fixed group of `N_TERMS` consecutive valid products into a wider accumulator. At the end of each group it presents the registered sum with a one-cycle valid strobe for the next stage. Groups run back-to-back with no dead cycles.

## Interface
Parameters:
- `N_TERMS`, 4: products per group; legal range 1..255.
- `ACC_W`, 18: accumulator and sum width; legal range 16..32.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ena`  in  1  product valid; driven by the multiplier's `ena_out`.
- `product`  in  16  unsigned product; sampled only when `ena`=1.
- `clear`  in  1  synchronous abort of the partial group.
- `sum`  out  ACC_W  registered group result; held until the next group completes.
- `ena_out`  out  1  one-cycle strobe; `sum` and `ovf` are valid in this cycle.
- `ovf`  out  1  overflow flag for the group reported with the last `ena_out`.
- `count`  out  8  number of terms accumulated in the current group, 0..N_TERMS-1.

## Operation
- Unsigned arithmetic only. The product is zero-extended to ACC_W before the add.
- FSM states:
  - IDLE: `count`=0, accumulator is 0.
  - ACC: `count` is 1..N_TERMS-1.
- IDLE + `ena`:
  - Accumulator is loaded with `product`; `count`=1; next state is ACC.
  - If N_TERMS=1, the group completes instead (see group completion below).
- ACC + `ena`:
  - Accumulator is updated with `product` added; `count` increments.
- Group completion (the N_TERMS-th `ena`):
  - `sum` is loaded with the final value, `ena_out` is set to 1, `ovf` is loaded with the group's overflow status.
  - Accumulator and `count` return to 0; next state is IDLE.
- `ena`=0: no state change. Gaps between products are allowed and do not affect the result.
- Overflow: carry out of bit ACC_W-1 on any add within the group sets an internal sticky bit. The sticky bit is cleared at group start.
- `clear`=1:
  - Discards the partial accumulator, `count`, and the sticky overflow bit.
  - `sum`, `ovf` and the outputs of already completed groups are unaffected.
- `clear` together with `ena`: the product becomes term 1 of a fresh group (`count`=1; with N_TERMS=1 it completes immediately).
- `rst` has priority over `clear` and `ena`.

## Timing
- Reset values: `sum`=0, `ena_out`=0, `ovf`=0, `count`=0, state IDLE, accumulator 0.
- Latency: `ena_out`=1 in the cycle following the edge that samples the N_TERMS-th `ena`. There is 1 cycle from the last product to the strobe.
- `ena_out` is high for exactly one cycle per group and is never high for two consecutive cycles unless N_TERMS=1 and `ena` is high on consecutive cycles.
- Back-to-back groups: an `ena` in the same cycle as `ena_out` is term 1 of the next group.
- `rst` mid-group: the partial group is lost and no `ena_out` is produced for it.
- No backpressure. The consumer must accept `sum` in the `ena_out` cycle or read the held value before the next group completes.

## Configuration
- `PRODUCT_ACC_SATURATE_EN` defined:
  - On overflow the accumulator clamps to 2^ACC_W−1 and stays clamped for the rest of the group.
  - `ovf` is still reported.
- `PRODUCT_ACC_SATURATE_EN` undefined: the accumulator wraps modulo 2^ACC_W; `ovf` is reported.

## Structure
- Package `product_acc_pkg`:
  - FSM state enum (IDLE, ACC).
  - `CNT_W`=8.
  - Constant `PRODUCT_W`=16.
- Sub-module `acc_adder`: combinational ACC_W + 16 adder. It returns the next accumulator value and a carry/overflow bit, and contains the saturate/wrap selection under `PRODUCT_ACC_SATURATE_EN`. The top level holds the FSM, counter and output registers.

## Test plan
- N_TERMS=4, ACC_W=18; products 100, 200, 300, 400 on consecutive cycles → one `ena_out` pulse with `sum`=1000 and `ovf`=0; `count` goes 1, 2, 3, 0.
- Same products with 2 idle cycles between each → `sum`=1000, and the strobe comes 1 cycle after the 4th `ena`.
- 8 consecutive products of value 10 → two strobes 4 cycles apart, each with `sum`=40; no dead cycle between groups.
- ACC_W=17; four products of 65025:
  - Without the macro → `sum`=129028, `ovf`=1.
  - With the macro → `sum`=131071, `ovf`=1.
  - The next group of four 1s gives `sum`=4 and `ovf`=0.
- After 2 products, assert `rst` → all outputs 0. Then feed 4 products of 5 → `sum`=20.
- After 3 products, assert `clear` together with `ena`(product=7), then 3 products of 1 → `sum`=10. The previous `sum` is held until then.
